// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the shift arbiter and its shifter datapath.
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int CTL_RIGHT   = 1;
  localparam int CTL_LOGICAL = 0;
  localparam int SHAMT_W     = 5;

  // Left shifts are always logical: the shifter's arithmetic-left mode fills LSBs with A[31].
  function automatic logic shape_ctl0(input logic [1:0] ctl);
    return ctl[CTL_RIGHT] ? ctl[CTL_LOGICAL] : 1'b1;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the arbiter.
// A request transfers on the cycle req_ready[i] is high; req_valid[i] and operands hold until then.
// A response transfers at a clock edge where rsp_valid && rsp_ready; rsp_* hold until then.
interface shift_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [1:0]  req0_ctl;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  req1_ctl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;

  modport slave (
    input  req_valid, req0_a, req0_b, req0_ctl, req1_a, req1_b, req1_ctl, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req0_a, req0_b, req0_ctl, req1_a, req1_b, req1_ctl, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter: ctl1=1 right/0 left, ctl0=1 logical/0 arithmetic (fill with A[31]).
module shifter
  import shift_pkg::*;
(
  output logic [31:0] out_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ctl0_i,
  input  logic        ctl1_i
);

  logic [SHAMT_W-1:0] shamt;
  logic               oversize;
  logic [31:0]        fill;

  assign shamt    = b_i[SHAMT_W-1:0];
  assign oversize = |b_i[31:SHAMT_W];
  assign fill     = ctl0_i ? 32'h0 : {32{a_i[31]}};

  always_comb begin
    out_o = '0;
    if (oversize) begin
      out_o = fill;
    end else if (ctl1_i) begin
      out_o = ctl0_i ? (a_i >> shamt) : 32'($signed(a_i) >>> shamt);
    end else begin
      out_o = (a_i << shamt) | (~(32'hFFFF_FFFF << shamt) & fill);
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters; operands are held
// registered for SETTLE_CYCLES clocks before the result is captured and returned tagged.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_arbiter_if.slave  bus,
  output state_e          dbg_state_o
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rr_last_q, rr_last_d;
  logic        grant_q, grant_d;
  logic [1:0]  req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] sh_a_q, sh_a_d;
  logic [31:0] sh_b_q, sh_b_d;
  logic        sh_ctl0_q, sh_ctl0_d;
  logic        sh_ctl1_q, sh_ctl1_d;
  logic [31:0] sh_out;

  logic        win;
  logic [31:0] sel_a, sel_b;
  logic [1:0]  sel_ctl;
  logic        unused_b_hi;

  assign unused_b_hi = ^{bus.req0_b[31:SHAMT_W], bus.req1_b[31:SHAMT_W]};

  // A tie goes to the requester that did not win last time.
  assign win     = (bus.req_valid == 2'b11) ? ~rr_last_q : bus.req_valid[1];
  assign sel_a   = win ? bus.req1_a   : bus.req0_a;
  assign sel_b   = win ? bus.req1_b   : bus.req0_b;
  assign sel_ctl = win ? bus.req1_ctl : bus.req0_ctl;

  shifter u_shifter (
    .out_o  (sh_out),
    .a_i    (sh_a_q),
    .b_i    (sh_b_q),
    .ctl0_i (sh_ctl0_q),
    .ctl1_i (sh_ctl1_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_last_d   = rr_last_q;
    grant_d     = grant_q;
    req_ready_d = 2'b00;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    sh_ctl0_d   = sh_ctl0_q;
    sh_ctl1_d   = sh_ctl1_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          req_ready_d = win ? 2'b10 : 2'b01;
          sh_a_d      = sel_a;
          sh_b_d      = {27'b0, sel_b[SHAMT_W-1:0]};
          sh_ctl1_d   = sel_ctl[CTL_RIGHT];
          sh_ctl0_d   = shape_ctl0(sel_ctl);
          rr_last_d   = win;
          grant_d     = win;
          cnt_d       = CNT_LOAD;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = sh_out;
          rsp_id_d    = grant_q;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rr_last_q   <= 1'b1;
      grant_q     <= 1'b0;
      req_ready_q <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'h0;
      sh_a_q      <= 32'h0;
      sh_b_q      <= 32'h0;
      sh_ctl0_q   <= 1'b0;
      sh_ctl1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      sh_ctl0_q   <= sh_ctl0_d;
      sh_ctl1_q   <= sh_ctl1_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: single ops, round robin, response backpressure, reset abort.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;
  int     total;
  int     bad;

  shift_arbiter_if bus ();

  shift_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ctl);
    if (id == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_ctl = ctl;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_ctl = ctl;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, "_rvalid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_rid"}, 32'(bus.rsp_id), 32'h0);
    check({tag, "_rdata"}, bus.rsp_data, 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // One isolated request: accept pulse, two-clock latency, then handshake back to idle.
  task automatic run_op(input string tag, input int id, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] ctl, input logic [31:0] exp);
    set_req(id, a, b, ctl);
    bus.req_valid = (id == 0) ? 2'b01 : 2'b10;
    bus.rsp_ready = 1'b0;
    tick();
    check({tag, "_accept"}, 32'(bus.req_ready), (id == 0) ? 32'h1 : 32'h2);
    bus.req_valid = 2'b00;
    tick();
    check({tag, "_ready_pulse"}, 32'(bus.req_ready), 32'h0);
    check({tag, "_early"}, 32'(bus.rsp_valid), 32'h0);
    tick();
    check({tag, "_rvalid"}, 32'(bus.rsp_valid), 32'h1);
    check({tag, "_rid"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_rdata"}, bus.rsp_data, exp);
    bus.rsp_ready = 1'b1;
    tick();
    check({tag, "_drop"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_idle"}, 32'(dbg_state), 32'(S_IDLE));
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    set_req(0, 32'h0, 32'h0, 2'b00);
    set_req(1, 32'h0, 32'h0, 2'b00);
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_op("t1_arith_right", 0, 32'h8000_0000, 32'd4, 2'b10, 32'hF800_0000);
    run_op("t3_left_forced", 0, 32'h8000_000F, 32'd4, 2'b00, 32'h0000_00F0);
    run_op("arith_right_31", 0, 32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF);
    run_op("t2_b_masked", 1, 32'h8000_0000, 32'h0000_0024, 2'b11, 32'h0800_0000);

    // Both requesters valid, consumer always ready: grants alternate starting at req0.
    set_req(0, 32'h0000_0001, 32'd1, 2'b00);
    set_req(1, 32'h0000_0100, 32'd4, 2'b11);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check("rr_pulse", 32'(bus.req_ready), 32'h0);
      tick();
      check("rr_rvalid", 32'(bus.rsp_valid), 32'h1);
      check("rr_rid", 32'(bus.rsp_id), 32'(k % 2));
      check("rr_rdata", bus.rsp_data, (k % 2 == 0) ? 32'h0000_0002 : 32'h0000_0010);
      if (k == 3) bus.req_valid = 2'b00;
      tick();
      check("rr_drop", 32'(bus.rsp_valid), 32'h0);
    end
    tick();
    check("rr_quiet", 32'(bus.req_ready), 32'h0);

    // Consumer stalls in DONE while req1 waits.
    bus.rsp_ready = 1'b0;
    set_req(0, 32'h0000_00F0, 32'd4, 2'b11);
    set_req(1, 32'h8000_0001, 32'd31, 2'b00);
    bus.req_valid = 2'b01;
    tick();
    check("bp_accept0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b10;
    tick();
    tick();
    check("bp_rvalid", 32'(bus.rsp_valid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_hold_data", bus.rsp_data, 32'h0000_000F);
      check("bp_hold_id", 32'(bus.rsp_id), 32'h0);
      check("bp_no_ready", 32'(bus.req_ready), 32'h0);
      check("bp_state", 32'(dbg_state), 32'(S_DONE));
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_drop", 32'(bus.rsp_valid), 32'h0);
    check("bp_no_early_accept", 32'(bus.req_ready), 32'h0);
    tick();
    check("bp_accept1", 32'(bus.req_ready), 32'h2);
    bus.req_valid = 2'b00;
    tick();
    tick();
    check("bp_r1_valid", 32'(bus.rsp_valid), 32'h1);
    check("bp_r1_id", 32'(bus.rsp_id), 32'h1);
    check("bp_r1_data", bus.rsp_data, 32'h8000_0000);
    tick();
    check("bp_r1_drop", 32'(bus.rsp_valid), 32'h0);

    // Reset during RUN aborts silently; the first tie afterwards goes to req0.
    bus.rsp_ready = 1'b0;
    set_req(0, 32'h1234_5678, 32'd8, 2'b11);
    bus.req_valid = 2'b01;
    tick();
    check("rst_accept0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    tick();
    check("rst_in_run", 32'(dbg_state), 32'(S_RUN));
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rst_abort");
    tick();
    check("rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
    set_req(1, 32'h0000_FF00, 32'd8, 2'b11);
    bus.req_valid = 2'b11;
    rst_n = 1'b1;
    tick();
    check("rst_tie_req0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b10;
    tick();
    tick();
    check("rst_r0_valid", 32'(bus.rsp_valid), 32'h1);
    check("rst_r0_id", 32'(bus.rsp_id), 32'h0);
    check("rst_r0_data", bus.rsp_data, 32'h0012_3456);
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_accept1", 32'(bus.req_ready), 32'h2);
    bus.req_valid = 2'b00;
    tick();
    tick();
    check("rst_r1_id", 32'(bus.rsp_id), 32'h1);
    check("rst_r1_data", bus.rsp_data, 32'h0000_00FF);
    tick();
    check("rst_end_idle", 32'(dbg_state), 32'(S_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
